// File: rtl/peripheral_arbiter_wb.sv
// peripheral_arbiter_wb: round-robin Wishbone B3 arbiter sharing one slave among NUM_MASTERS masters.
// Optional stalled-transfer timeout: define PERIPHERAL_ARBITER_WB_TIMEOUT_EN.
module peripheral_arbiter_wb #(
    parameter int NUM_MASTERS = 2,
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [NUM_MASTERS*AW-1:0] wbm_adr_i,
    input  logic [NUM_MASTERS*DW-1:0] wbm_dat_i,
    input  logic [NUM_MASTERS*4-1:0]  wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]    wbm_we_i,
    input  logic [NUM_MASTERS*3-1:0]  wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]  wbm_bte_i,
    input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
    output logic [NUM_MASTERS-1:0]    wbm_ack_o,
    output logic [NUM_MASTERS-1:0]    wbm_err_o,
    output logic [NUM_MASTERS*DW-1:0] wbm_dat_o,
    output logic [AW-1:0]             wbs_adr_o,
    output logic [DW-1:0]             wbs_dat_o,
    output logic [3:0]                wbs_sel_o,
    output logic                      wbs_we_o,
    output logic [2:0]                wbs_cti_o,
    output logic [1:0]                wbs_bte_o,
    output logic                      wbs_cyc_o,
    output logic                      wbs_stb_o,
    input  logic                      wbs_ack_i,
    input  logic                      wbs_err_i,
    input  logic [DW-1:0]             wbs_dat_i
);
    localparam int IW = $clog2(NUM_MASTERS);

    logic          r_gnt_vld;
    logic [IW-1:0] r_gnt_idx;
    logic [IW-1:0] r_last_idx;
    logic [IW-1:0] w_win;
    logic          w_any;
    logic          w_rel;
    logic          w_tmo;
    logic          w_g;

    assign w_any = |wbm_cyc_i;
    assign w_g   = r_gnt_vld & ~wb_rst_i;
    assign w_rel = ~wbm_cyc_i[r_gnt_idx] | w_tmo;

    // First requester after last_idx; scanning downward lets the nearest one win
    always_comb begin
        w_win = r_last_idx;
        for (int k = NUM_MASTERS; k >= 1; k--)
            if (wbm_cyc_i[IW'((int'(r_last_idx) + k) % NUM_MASTERS)])
                w_win = IW'((int'(r_last_idx) + k) % NUM_MASTERS);
    end

    // Grant state: hold while the granted cyc is high, re-arbitrate on release
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_gnt_vld  <= 1'b0;
            r_gnt_idx  <= '0;
            r_last_idx <= IW'(NUM_MASTERS - 1);
        end else if (!r_gnt_vld || w_rel) begin
            r_gnt_vld <= w_any;
            if (w_any) begin
                r_gnt_idx  <= w_win;
                r_last_idx <= w_win;
            end
        end
    end

`ifdef PERIPHERAL_ARBITER_WB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_tmo;

    assign w_tmo = r_gnt_vld && (r_tmo == CW'(TIMEOUT));

    // Count cycles the granted strobe waits without a slave response
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            r_tmo <= '0;
        else if (!r_gnt_vld || w_rel || wbs_ack_i || wbs_err_i)
            r_tmo <= '0;
        else if (wbs_stb_o)
            r_tmo <= r_tmo + 1'b1;
    end
`else
    assign w_tmo = (TIMEOUT < 0);
`endif

    // Mux the granted master onto the slave and route responses back to it
    always_comb begin
        wbs_adr_o = w_g ? wbm_adr_i[int'(r_gnt_idx)*AW +: AW] : '0;
        wbs_dat_o = w_g ? wbm_dat_i[int'(r_gnt_idx)*DW +: DW] : '0;
        wbs_sel_o = w_g ? wbm_sel_i[int'(r_gnt_idx)*4 +: 4] : '0;
        wbs_cti_o = w_g ? wbm_cti_i[int'(r_gnt_idx)*3 +: 3] : '0;
        wbs_bte_o = w_g ? wbm_bte_i[int'(r_gnt_idx)*2 +: 2] : '0;
        wbs_we_o  = w_g & wbm_we_i[r_gnt_idx];
        wbs_cyc_o = w_g & wbm_cyc_i[r_gnt_idx] & ~w_tmo;
        wbs_stb_o = w_g & wbm_stb_i[r_gnt_idx] & ~w_tmo;
        wbm_dat_o = wb_rst_i ? '0 : {NUM_MASTERS{wbs_dat_i}};
        wbm_ack_o = '0;
        wbm_err_o = '0;
        if (w_g) begin
            wbm_ack_o[r_gnt_idx] = wbs_ack_i;
            wbm_err_o[r_gnt_idx] = wbs_err_i | w_tmo;
        end
    end
endmodule

// File: tb/tb_peripheral_arbiter_wb.sv
// tb_peripheral_arbiter_wb: directed table and sequence checks for the round-robin Wishbone arbiter.
module tb_peripheral_arbiter_wb;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0][31:0] m_adr;
    logic [1:0][31:0] m_dat;
    logic [1:0][3:0]  m_sel;
    logic [1:0]       m_we;
    logic [1:0][2:0]  m_cti;
    logic [1:0][1:0]  m_bte;
    logic [1:0]       m_cyc;
    logic [1:0]       m_stb;
    logic [1:0]       ack_o;
    logic [1:0]       err_o;
    logic [63:0]      mdat_o;
    logic [31:0]      s_adr;
    logic [31:0]      s_dat;
    logic [3:0]       s_sel;
    logic             s_we;
    logic [2:0]       s_cti;
    logic [1:0]       s_bte;
    logic             s_cyc;
    logic             s_stb;
    logic             s_ack;
    logic             s_err;
    logic [31:0]      s_rdat;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  cyc;
        logic [1:0]  stb;
        logic        ack;
        logic        err;
        logic        cyc_o;
        logic [31:0] adr;
        logic [1:0]  ack_o;
        logic [1:0]  err_o;
    } vec_t;

    vec_t tbl [14];

    peripheral_arbiter_wb #(.NUM_MASTERS(2), .DW(32), .AW(32), .TIMEOUT(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
        .wbm_cti_i(m_cti), .wbm_bte_i(m_bte), .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb),
        .wbm_ack_o(ack_o), .wbm_err_o(err_o), .wbm_dat_o(mdat_o),
        .wbs_adr_o(s_adr), .wbs_dat_o(s_dat), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
        .wbs_cti_o(s_cti), .wbs_bte_o(s_bte), .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb),
        .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_dat_i(s_rdat)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int g;
        logic [31:0] exp_dat;
        tbl[0]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h00, 2'b00, 2'b00};
        tbl[1]  = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 32'h00, 2'b00, 2'b00};
        tbl[2]  = '{2'b11, 2'b11, 1'b1, 1'b0, 1'b1, 32'h10, 2'b01, 2'b00};
        tbl[3]  = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 32'h10, 2'b00, 2'b00};
        tbl[4]  = '{2'b10, 2'b10, 1'b1, 1'b0, 1'b1, 32'h20, 2'b10, 2'b00};
        tbl[5]  = '{2'b11, 2'b11, 1'b1, 1'b0, 1'b1, 32'h20, 2'b10, 2'b00};
        tbl[6]  = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 32'h20, 2'b00, 2'b00};
        tbl[7]  = '{2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 32'h10, 2'b01, 2'b00};
        tbl[8]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h10, 2'b00, 2'b00};
        tbl[9]  = '{2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 32'h00, 2'b00, 2'b00};
        tbl[10] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h10, 2'b00, 2'b00};
        tbl[11] = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 32'h00, 2'b00, 2'b00};
        tbl[12] = '{2'b01, 2'b01, 1'b0, 1'b1, 1'b1, 32'h10, 2'b00, 2'b01};
        tbl[13] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h10, 2'b00, 2'b00};

        m_adr[0] = 32'h10; m_dat[0] = 32'hDEADBEEF; m_sel[0] = 4'hF; m_we[0] = 1'b1;
        m_adr[1] = 32'h20; m_dat[1] = 32'h11111111; m_sel[1] = 4'h3; m_we[1] = 1'b0;
        m_cti = '0; m_bte = '0; m_cyc = '0; m_stb = '0;
        s_ack = 1'b0; s_err = 1'b0; s_rdat = 32'hCAFEF00D;
        tick(); tick();
        rst = 1'b0;
        tick();

        // reset asserted mid-idle: everything zero with no clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_idle_cyc", {s_cyc, s_stb}, 2'b00);
        chk("rst_idle_ackerr", {ack_o, err_o}, 4'b0000);
        chk("rst_idle_mdat", mdat_o, 64'h0);
        chk("rst_idle_sadr", s_adr, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // table-driven grant / release / handover vectors
        for (int i = 0; i < 14; i++) begin
            m_cyc = tbl[i].cyc; m_stb = tbl[i].stb; s_ack = tbl[i].ack; s_err = tbl[i].err;
            #1;
            exp_dat = tbl[i].adr == 32'h10 ? 32'hDEADBEEF : tbl[i].adr == 32'h20 ? 32'h11111111 : 32'h0;
            chk($sformatf("tbl%0d_cyc", i), {s_cyc, s_stb}, {tbl[i].cyc_o, tbl[i].cyc_o});
            chk($sformatf("tbl%0d_adr", i), s_adr, tbl[i].adr);
            chk($sformatf("tbl%0d_dat", i), s_dat, exp_dat);
            chk($sformatf("tbl%0d_we", i), s_we, tbl[i].adr == 32'h10);
            chk($sformatf("tbl%0d_ack", i), ack_o, tbl[i].ack_o);
            chk($sformatf("tbl%0d_err", i), err_o, tbl[i].err_o);
            if (i == 2) chk("mdat_repl", mdat_o, {2{32'hCAFEF00D}});
            tick();
        end

        // both masters keep requesting, single transfers: grant alternates (last grant was M0)
        m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (!s_cyc && n < 8) begin
                tick();
                n++;
            end
            chk($sformatf("rr%0d_wait", k), n < 8, 1'b1);
            g = s_adr == 32'h20 ? 1 : 0;
            chk($sformatf("rr%0d_gnt", k), g, (k + 1) % 2);
            s_ack = 1'b1;
            #1;
            chk($sformatf("rr%0d_ack", k), ack_o, g == 1 ? 2'b10 : 2'b01);
            tick();
            s_ack = 1'b0; m_cyc[g] = 1'b0; m_stb[g] = 1'b0;
            tick();
            m_cyc[g] = 1'b1; m_stb[g] = 1'b1;
        end
        m_cyc = 2'b00; m_stb = 2'b00;
        tick();

        // M1 incrementing burst while M0 waits
        m_cyc = 2'b10; m_stb = 2'b10;
        tick();
        m_cyc = 2'b11; m_stb = 2'b11;
        for (int b = 0; b < 4; b++) begin
            m_adr[1] = 32'h20 + 32'(4 * b);
            m_cti[1] = b < 3 ? 3'b010 : 3'b111;
            s_ack = 1'b1;
            #1;
            chk($sformatf("burst%0d_adr", b), s_adr, 32'h20 + 32'(4 * b));
            chk($sformatf("burst%0d_cti", b), {s_cti, s_bte}, {(b < 3 ? 3'b010 : 3'b111), 2'b00});
            chk($sformatf("burst%0d_ack", b), ack_o, 2'b10);
            tick();
        end
        s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_adr[1] = 32'h20; m_cti[1] = 3'b000;
        #1;
        chk("burst_end_cyc", s_cyc, 1'b0);
        chk("burst_end_m0ack", ack_o, 2'b00);
        tick();
        chk("burst_handover", {s_cyc, s_adr}, {1'b1, 32'h10});

        // async reset pulse during beat 2 of an M0 burst
        m_cti[0] = 3'b010; s_ack = 1'b1;
        tick();
        m_adr[0] = 32'h14;
        #1 rst = 1'b1;
        #1;
        chk("rst_burst_cycstb", {s_cyc, s_stb}, 2'b00);
        chk("rst_burst_ack", ack_o, 2'b00);
        tick();
        rst = 1'b0; s_ack = 1'b0; m_adr[0] = 32'h10; m_cti[0] = 3'b000;
        m_cyc = 2'b11; m_stb = 2'b11;
        #1;
        chk("post_rst_idle", s_cyc, 1'b0);
        tick();
        chk("post_rst_m0_first", {s_cyc, s_adr}, {1'b1, 32'h10});

`ifdef PERIPHERAL_ARBITER_WB_TIMEOUT_EN
        // slave never acks M0: error pulse in the ninth stalled cycle, then M1
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("tmo_stall%0d", c), {s_cyc, err_o}, {1'b1, 2'b00});
            tick();
        end
        chk("tmo_err", {s_cyc, s_stb, err_o}, {2'b00, 2'b01});
        tick();
        chk("tmo_next_m1", {s_cyc, s_adr, err_o}, {1'b1, 32'h20, 2'b00});
`else
        // without the timeout a stalled grant is held indefinitely
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("stall_hold%0d", c), {s_cyc, s_adr, err_o}, {1'b1, 32'h10, 2'b00});
            tick();
        end
`endif
        m_cyc = 2'b00; m_stb = 2'b00;
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/peripheral_arbiter_wb.md
Name: peripheral_arbiter_wb

Overview:
Round-robin Wishbone B3 arbiter that shares one slave, typically peripheral_spram_wb, among NUM_MASTERS masters.
- Grant is registered and held for the whole bus cycle (cyc high), so classic and incrementing/wrapping bursts pass through unbroken.
- All master-to-slave and slave-to-master signals are muxed combinationally by the registered grant.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
DW, 32, data width
AW, 32, address width
TIMEOUT, 255, stalled-transfer cycle limit (used only with the optional feature)

Ports:
wb_clk_i  input  1  clock
wb_rst_i  input  1  reset, asynchronous, active-high
wbm_adr_i  input  NUM_MASTERS*AW  master addresses, master i at [i*AW +: AW]
wbm_dat_i  input  NUM_MASTERS*DW  master write data
wbm_sel_i  input  NUM_MASTERS*4  byte selects
wbm_we_i  input  NUM_MASTERS  write enables
wbm_cti_i  input  NUM_MASTERS*3  cycle type ids
wbm_bte_i  input  NUM_MASTERS*2  burst type extensions
wbm_cyc_i  input  NUM_MASTERS  cycle requests
wbm_stb_i  input  NUM_MASTERS  strobes
wbm_ack_o  output  NUM_MASTERS  acks
wbm_err_o  output  NUM_MASTERS  errors
wbm_dat_o  output  NUM_MASTERS*DW  read data, slave data replicated to all masters
wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o  output  AW, DW, 4, 1, 3, 2  to slave
wbs_cyc_o, wbs_stb_o  output  1 each  to slave
wbs_ack_i, wbs_err_i  input  1 each  from slave
wbs_dat_i  input  DW  slave read data

Behaviour:
- State registers:
  - gnt_vld: 1 bit.
  - gnt_idx: clog2(NUM_MASTERS) bits.
  - last_idx: initialised to NUM_MASTERS-1, so master 0 wins first after reset.
- Reset is asynchronous. It clears gnt_vld and gnt_idx, and sets last_idx to NUM_MASTERS-1.
- All outputs are 0 while in reset. wbs_cyc_o and wbs_stb_o fall immediately, without waiting for a clock edge.
- IDLE (gnt_vld=0):
  - Slave cyc/stb are 0.
  - When any wbm_cyc_i is high, the winner is the first requester found scanning last_idx+1, last_idx+2, ... modulo NUM_MASTERS.
  - At the next edge: gnt_vld=1, gnt_idx=winner, last_idx=winner.
  - Grant latency: 1 cycle after cyc rises.
- GRANT (gnt_vld=1):
  - wbs_* outputs equal master gnt_idx's signals; wbs_cyc_o = wbm_cyc_i[gnt_idx].
  - wbm_ack_o[gnt_idx] = wbs_ack_i; wbm_err_o[gnt_idx] = wbs_err_i; all other ack/err bits are 0.
- Release: in a cycle where wbm_cyc_i[gnt_idx]=0, the next edge re-arbitrates.
  - If another master requests, the grant moves directly to it (GRANT->GRANT). Otherwise return to IDLE.
  - A master that releases cannot win the next arbitration if another master is requesting.
- No switching while the granted cyc is high, regardless of cti. The burst end (cti=111) is honoured by the master dropping cyc.
- Requests from non-granted masters see ack/err = 0 and wait indefinitely. The arbiter never drops them.
- Simultaneous release and new request by the same master alone: the master is re-granted after a 1-cycle gap with slave cyc=0.
- wbs_dat_i is replicated to every wbm_dat_o slice. Masters qualify read data with their own ack.

Optional Feature:
Macro PERIPHERAL_ARBITER_WB_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle gnt_vld & wbs_stb_o & !wbs_ack_i & !wbs_err_i. It clears on ack, err or grant change.
  - When the counter reaches TIMEOUT, wbm_err_o[gnt_idx] pulses for 1 cycle and wbs_cyc_o/wbs_stb_o are forced to 0 in that cycle.
  - The grant is then released at the next edge, and last_idx advances past the stalled master.
- Undefined: no counter, no forced error, and the grant is held until the master drops cyc.

Test Plan:
1. Reset asserted mid-idle, all masters idle -> all wbs_* and wbm_ack/err outputs 0; wbs_cyc_o=0 with no clock edge.
2. M0 and M1 raise cyc/stb at the same edge, classic write addr 0x10 data 0xDEADBEEF -> wbs_cyc_o high 1 cycle later with M0's address. M1 stalls with ack=0. After M0 drops cyc, M1 is granted at the next edge.
3. M0 and M1 hold cyc continuously, each doing single classic transfers -> grant sequence alternates 0,1,0,1 across 8 transfers.
4. M1 runs a 4-beat incrementing burst (cti 010,010,010,111, bte 00) from 0x20 while M0 requests -> M1 receives 4 acks with addresses 0x20..0x2C, M0 has no ack until M1 drops cyc.
5. Async reset pulse during beat 2 of an M0 burst -> slave cyc/stb drop immediately; after reset release with M0 and M1 both requesting, M0 is granted first.
6. With PERIPHERAL_ARBITER_WB_TIMEOUT_EN and TIMEOUT=8, the slave never acks M0's strobe -> wbm_err_o[0] pulses after 8 stalled cycles, then M1 (requesting) is granted at the next edge.
